sa_ram_rws_param: RTL
=====================

Name: sa_ram_rws_param

Overview:
Parametrised 1-read/1-write synchronous RAM model for FPGA builds of the systolic-array buffers. It generalises the fixed 512x512 model with:
- configurable depth and width
- per-byte write enables
- a selectable read-during-write collision policy
- an optional output pipeline stage with a read-valid strobe
It sits under the SA buffer wrappers and is a drop-in for the fixed-size models once the extra ports are tied off.

Parameters:
DEPTH, 512, number of words; any value >=2, need not be a power of two
WIDTH, 512, bits per word; must be a multiple of 8
AW, 9, address width; must satisfy 2^AW >= DEPTH
DOUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
BYPASS, 1, 1 = write-first on same-address collision; 0 = read-first (old data)
FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, 1'b0, kept for compatibility; no functional effect

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
ra  input  AW  read address
re  input  1  read enable
dout  output  WIDTH  read data
dout_vld  output  1  one-cycle strobe: dout carries data for a read issued DOUT_REG+1 cycles earlier
wa  input  AW  write address
we  input  1  write enable
wbe  input  WIDTH/8  byte write enables; bit i covers di[8i+7:8i]
di  input  WIDTH  write data
busy  output  1  RAM not accepting accesses (init clear in progress)
pwrbus_ram_pd  input  32  power-down bus; ignored by the model

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low. Memory array is not reset.
- Reset values: dout=0, dout_vld=0, busy=0 (see Optional Feature), all internal pipeline registers 0.
- Write: on posedge clk with we=1, wa<DEPTH and busy=0, for each i with wbe[i]=1, M[wa] byte i <= di byte i. Bytes with wbe[i]=0 are unchanged. we=1 with wbe=0 is a no-op.
- Write to wa>=DEPTH: dropped, no side effects.
- Read: on posedge clk with re=1 and busy=0, the word is captured into the read data register. This is a true synchronous read.
  - dout is stable until the next accepted read; a later write to the same address does not disturb it.
  - re=0 holds dout.
  - ra>=DEPTH returns all-zero data.
- Latency:
  - DOUT_REG=0: data and dout_vld appear the cycle after re.
  - DOUT_REG=1: data passes through a second register and appears 2 cycles after re.
  - The stage-2 register loads only when stage 1 holds valid data; otherwise it holds.
  - dout_vld is 1 exactly one cycle per accepted read.
  - Back-to-back reads give back-to-back valid data, throughput 1 per cycle.
- Collision (re=1, we=1, ra==wa, in range, same edge):
  - BYPASS=1: returned word is, per byte, di where wbe=1, else old M content.
  - BYPASS=0: returned word is the old M content.
  - In both modes the memory is updated as for a normal write.
- Reads and writes to different addresses in the same cycle are independent.
- Reset mid-operation: in-flight reads are discarded (dout_vld=0, dout=0). Writes at or before the last completed edge persist.

Optional Feature:
Macro SA_RAM_INIT_CLEAR_EN.
- Defined:
  - A 2-state FSM (CLEAR, READY) enters CLEAR on reset with an address counter at 0.
  - In CLEAR, one word per cycle is written with all zeros (all bytes) at the counter address. busy=1.
  - While busy, user re and we are ignored and dout_vld stays 0.
  - After writing address DEPTH-1, the FSM moves to READY the next edge. busy=0 from that cycle on.
  - CLEAR lasts exactly DEPTH cycles after reset release.
  - Reset asserted during CLEAR restarts the clear from address 0.
- Not defined: busy is tied to 0. The array powers up uninitialised (X in simulation). Accesses are accepted from the first edge after reset release.

Test Plan:
- DEPTH=512, WIDTH=512, DOUT_REG=0: write 0xA5.. to addr 7, then re addr 7 -> dout=0xA5.. and dout_vld=1 one cycle after re. Subsequent write to addr 7 leaves dout unchanged.
- Byte enables: write 0xFF.. to addr 3, then write 0x00.. with wbe=0x1 -> read addr 3 gives 0xFF..FF00.
- Collision: addr 5 holds 0x11.., same-cycle we/re addr 5 with di=0x22.., wbe all-ones -> BYPASS=1 returns 0x22..; BYPASS=0 returns 0x11.. Both then read 0x22..
- DOUT_REG=1, reads on 4 consecutive cycles to addrs 0..3 -> 4 consecutive dout_vld pulses starting 2 cycles after the first re, data in order. Out-of-range ra (DEPTH=300, ra=400) -> dout=0.
- SA_RAM_INIT_CLEAR_EN, DEPTH=16: release rstn -> busy=1 for 16 cycles, then 0. Reads of all addrs return 0. Pulsing rstn at cycle 8 restarts the full 16-cycle clear. A we issued while busy has no effect.
- Async reset: assert rstn low between edges with a read in flight -> dout=0 and dout_vld=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sa_ram_rws_param.sv
// sa_ram_rws_param
//   Parametrised 1-read/1-write synchronous RAM model for FPGA builds of the
//   systolic-array buffers. It supports per-byte write enables, a selectable
//   read-during-write collision policy and an optional output register stage.
//
//   Optional feature macro: SA_RAM_INIT_CLEAR_EN
//     When defined, the array is zero-filled one word per cycle after reset,
//     and busy is held high until the fill completes. When undefined, busy is
//     tied low and the array is left uninitialised.
//
// Ports:
//   clk           clock
//   rstn          asynchronous active-low reset (memory array is not reset)
//   ra, re        read address / read enable
//   dout          read data (latency DOUT_REG+1)
//   dout_vld      one-cycle strobe per accepted read, aligned with dout
//   wa, we        write address / write enable
//   wbe           byte write enables, bit i covers di[8i+7:8i]
//   di            write data
//   busy          high while the init clear is running
//   pwrbus_ram_pd power-down bus, ignored by the model
module sa_ram_rws_param #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned WIDTH    = 512,
    parameter int unsigned AW       = 9,
    parameter int unsigned DOUT_REG = 0,
    parameter int unsigned BYPASS   = 1,
    parameter logic        FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [AW-1:0]      ra,
    input  logic               re,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_vld,
    input  logic [AW-1:0]      wa,
    input  logic               we,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [WIDTH-1:0]   di,
    output logic               busy,
    input  logic [31:0]        pwrbus_ram_pd
);

    localparam int unsigned NB       = WIDTH / 8;
    localparam int unsigned DEPTH_M1 = DEPTH - 1;
    // One extra bit so DEPTH == 2**AW is representable in the range compare.
    localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
    localparam logic [AW-1:0] LAST_ADR = DEPTH_M1[AW-1:0];

    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy_int;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    logic             ra_ok;
    logic             wa_ok;
    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] d1;
    logic             v1;

    logic             unused_pd;
    assign unused_pd = ^{pwrbus_ram_pd, 1'b0};

`ifdef SA_RAM_INIT_CLEAR_EN
    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_addr_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        busy_int     = 1'b0;
        clr_we       = 1'b0;
        case (state)
            CLEAR: begin
                busy_int = 1'b1;
                clr_we   = 1'b1;
                if (clr_addr == LAST_ADR) begin
                    state_nxt = READY;
                end else begin
                    clr_addr_nxt = clr_addr + 1'b1;
                end
            end
            default: ;
        endcase
    end
`else
    assign busy_int = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy  = busy_int;
    assign ra_ok = ({1'b0, ra} < DEPTH_W);
    assign wa_ok = ({1'b0, wa} < DEPTH_W);
    assign rd_en = re && !busy_int;
    assign wr_en = we && wa_ok && !busy_int;

    // Memory array: clear writes take priority (user writes are blocked while
    // busy anyway). No reset on the array itself.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[wa][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

    // Array read returns pre-edge contents (read-first); write-first is built
    // by overlaying the enabled write bytes on a same-address collision.
    always_comb begin
        rd_word = '0;
        if (ra_ok) begin
            rd_word = mem[ra];
            if ((BYPASS != 0) && wr_en && (wa == ra)) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (wbe[i]) begin
                        rd_word[8*i +: 8] = di[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_en;
            if (rd_en) begin
                d1 <= rd_word;
            end
        end
    end

    generate
        if (DOUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] d2;
            logic             v2;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign dout     = d2;
            assign dout_vld = v2;
        end else begin : g_noreg
            assign dout     = d1;
            assign dout_vld = v1;
        end
    endgenerate

endmodule
